// File: rtl/tx_chan_deframer_pkg.sv
// Shared definitions for the TX channel deframer: FSM encoding, CHDR header
// bit positions and the field layout of the o_tuser sideband word.
package tx_chan_deframer_pkg;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_TIME = 2'd1,
        ST_BODY = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam int HDR_ODD_BIT      = 34;
    localparam int HDR_SEQ_LSB      = 48;
    localparam int HDR_SEQ_W        = 12;
    localparam int HDR_EOB_BIT      = 60;
    localparam int HDR_HAS_TIME_BIT = 61;
    localparam int HDR_DROP_BIT     = 63;

    // o_tuser = {chan, odd, has_time, eob, last, seqnum, sid, time}
    localparam int TU_TIME_LSB     = 0;
    localparam int TU_SID_LSB      = 64;
    localparam int TU_SEQ_LSB      = 96;
    localparam int TU_LAST_BIT     = 108;
    localparam int TU_EOB_BIT      = 109;
    localparam int TU_HAS_TIME_BIT = 110;
    localparam int TU_ODD_BIT      = 111;
    localparam int TU_CHAN_LSB     = 112;
    localparam int TU_FIXED_W      = 112;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_fifo.sv
// First-word-fall-through FIFO of 2**SIZE entries; the head entry is visible
// the cycle after it is written. Synchronous active-low reset plus soft clear.
module axi_fifo #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready
);
    localparam int DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  wr_ptr_reg;
    logic [SIZE-1:0]  rd_ptr_reg;
    logic [SIZE:0]    count_reg;
    logic             push;
    logic             pop;

    // count never exceeds DEPTH, so its MSB alone flags full
    assign i_tready = ~count_reg[SIZE];
    assign o_tvalid = |count_reg;
    assign push     = i_tvalid & i_tready;
    assign pop      = o_tvalid & o_tready;
    assign o_tdata  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= i_tdata;
    end

endmodule

// File: rtl/tx_chan_deframer.sv
// Splits CHDR packets into sample beats tagged with header/time metadata.
// Optional per-channel sequence checking: define TX_DEFRAMER_SEQ_CHECK_EN.
module tx_chan_deframer
    import tx_chan_deframer_pkg::*;
#(
    parameter int  NUM_CHAN  = 2,
    parameter int  FIFO_SIZE = 5,
    parameter int  CNT_W     = 16,
    localparam int CHAN_W    = chan_width(NUM_CHAN)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [63:0]              i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [63:0]              o_tdata,
    output logic [CHAN_W+111:0]      o_tuser,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     seq_err,
    output logic                     chan_err,
    output logic [CNT_W-1:0]         err_count
);
    localparam int USER_W = CHAN_W + TU_FIXED_W;
    localparam int FIFO_W = USER_W + 64;

    state_t state_reg, state_next;
    logic        odd_reg, has_time_reg, eob_reg;
    logic [11:0] seqnum_reg;
    logic [31:0] sid_reg;
    logic [63:0] time_reg;
    logic        seq_err_reg, chan_err_reg;
    logic        seq_err_next, chan_err_next;
    logic [CNT_W-1:0] err_count_reg;

    logic        soft_rst, hdr_acc, hdr_in_range, err_event;
    logic [11:0] hdr_seq;
    logic [USER_W-1:0] body_user;
    logic [FIFO_W-1:0] fifo_in_data, fifo_out_data;
    logic        fifo_in_valid, fifo_in_ready;
    logic        unused_hdr_bits;

    assign soft_rst = !reset_n || clear;
    assign hdr_acc  = (state_reg == ST_HEAD) && i_tvalid;
    assign hdr_seq  = i_tdata[HDR_SEQ_LSB +: HDR_SEQ_W];
    // Range is judged on the whole sid so aliased ids (e.g. 2 on a 1-bit chan) are rejected
    assign hdr_in_range    = (i_tdata[31:0] < 32'(NUM_CHAN));
    assign unused_hdr_bits = ^{i_tdata[62], i_tdata[47:35], i_tdata[33:32]};

    always_comb begin
        state_next    = state_reg;
        chan_err_next = 1'b0;
        case (state_reg)
            ST_HEAD: if (i_tvalid) begin
                if (i_tlast)                         state_next = ST_HEAD;
                else if (i_tdata[HDR_DROP_BIT])      state_next = ST_DUMP;
                else if (!hdr_in_range) begin
                    state_next    = ST_DUMP;
                    chan_err_next = 1'b1;
                end
                else if (i_tdata[HDR_HAS_TIME_BIT])  state_next = ST_TIME;
                else                                 state_next = ST_BODY;
            end
            ST_TIME: if (i_tvalid) state_next = i_tlast ? ST_HEAD : ST_BODY;
            ST_BODY: if (i_tvalid && fifo_in_ready && i_tlast) state_next = ST_HEAD;
            ST_DUMP: if (i_tvalid && i_tlast) state_next = ST_HEAD;
            default: state_next = ST_HEAD;
        endcase
    end

`ifdef TX_DEFRAMER_SEQ_CHECK_EN
    logic [CHAN_W-1:0]   hdr_chan;
    logic [NUM_CHAN-1:0] seq_mis;
    assign hdr_chan = i_tdata[CHAN_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_seq
            logic [11:0] exp_seq_reg;
            logic        seq_valid_reg;
            logic        hit;
            assign hit = hdr_acc && hdr_in_range && (hdr_chan == CHAN_W'(gi));
            always_ff @(posedge clk) begin
                if (soft_rst) begin
                    exp_seq_reg   <= '0;
                    seq_valid_reg <= 1'b0;
                end else if (hit) begin
                    exp_seq_reg   <= hdr_seq + 12'd1;
                    seq_valid_reg <= 1'b1;
                end
            end
            assign seq_mis[gi] = hit && seq_valid_reg && (exp_seq_reg != hdr_seq);
        end
    endgenerate
    assign seq_err_next = |seq_mis;
`else
    assign seq_err_next = 1'b0;
`endif

    assign err_event = seq_err_next | chan_err_next;

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_reg    <= ST_HEAD;
            odd_reg      <= 1'b0;
            has_time_reg <= 1'b0;
            eob_reg      <= 1'b0;
            seqnum_reg   <= '0;
            sid_reg      <= '0;
            time_reg     <= '0;
            seq_err_reg  <= 1'b0;
            chan_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            seq_err_reg  <= seq_err_next;
            chan_err_reg <= chan_err_next;
            if (hdr_acc) begin
                odd_reg      <= i_tdata[HDR_ODD_BIT];
                has_time_reg <= i_tdata[HDR_HAS_TIME_BIT];
                eob_reg      <= i_tdata[HDR_EOB_BIT];
                seqnum_reg   <= hdr_seq;
                sid_reg      <= i_tdata[31:0];
            end
            if (state_reg == ST_TIME && i_tvalid) time_reg <= i_tdata;
        end
    end

    // Error count survives a soft clear; only the hard reset zeroes it
    always_ff @(posedge clk) begin
        if (!reset_n)
            err_count_reg <= '0;
        else if (!clear && err_event && (err_count_reg != '1))
            err_count_reg <= err_count_reg + 1'b1;
    end

    always_comb begin
        body_user = '0;
        body_user[TU_TIME_LSB +: 64]     = time_reg;
        body_user[TU_SID_LSB +: 32]      = sid_reg;
        body_user[TU_SEQ_LSB +: 12]      = seqnum_reg;
        body_user[TU_LAST_BIT]           = i_tlast;
        body_user[TU_EOB_BIT]            = eob_reg;
        body_user[TU_HAS_TIME_BIT]       = has_time_reg;
        body_user[TU_ODD_BIT]            = odd_reg;
        body_user[TU_CHAN_LSB +: CHAN_W] = sid_reg[CHAN_W-1:0];
    end

    assign fifo_in_data  = {body_user, i_tdata};
    assign fifo_in_valid = (state_reg == ST_BODY) && i_tvalid;
    assign i_tready      = (state_reg == ST_BODY) ? fifo_in_ready : 1'b1;

    axi_fifo #(
        .WIDTH (FIFO_W),
        .SIZE  (FIFO_SIZE)
    ) u_axi_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .i_tdata  (fifo_in_data),
        .i_tvalid (fifo_in_valid),
        .i_tready (fifo_in_ready),
        .o_tdata  (fifo_out_data),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    assign o_tdata   = fifo_out_data[63:0];
    assign o_tuser   = fifo_out_data[64 +: USER_W];
    assign seq_err   = seq_err_reg;
    assign chan_err  = chan_err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_tx_chan_deframer.sv
// Directed bench for tx_chan_deframer (NUM_CHAN=2, FIFO_SIZE=1): packet table
// plus hand-written stall, reset and clear sequences.
module tb_tx_chan_deframer;

`ifdef TX_DEFRAMER_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic [63:0]  i_tdata;
    logic         i_tlast;
    logic         i_tvalid;
    logic         i_tready;
    logic [63:0]  o_tdata;
    logic [112:0] o_tuser;
    logic         o_tvalid;
    logic         o_tready;
    logic         seq_err;
    logic         chan_err;
    logic [15:0]  err_count;

    tx_chan_deframer #(
        .NUM_CHAN  (2),
        .FIFO_SIZE (1),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tuser   (o_tuser),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .seq_err   (seq_err),
        .chan_err  (chan_err),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] sid;
        logic [11:0] seq;
        logic        odd;
        logic        has_time;
        logic        eob;
        logic        drop;
        logic [63:0] tim;
        int          nbody;
        int          exp_out;
        int          exp_seq;
        int          exp_chan;
    } pkt_t;

    int n_checks = 0;
    int n_fail   = 0;
    int seq_seen = 0;
    int chan_seen = 0;
    int stall_cnt = 0;
    logic [63:0]  model_time = '0;
    logic [63:0]  out_d [$];
    logic [112:0] out_u [$];
    pkt_t tbl [10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic drop, input logic has_time, input logic eob,
                                           input logic [11:0] seq, input logic odd, input logic [31:0] sid);
        logic [63:0] h;
        h = '0;
        h[63] = drop;
        h[61] = has_time;
        h[60] = eob;
        h[59:48] = seq;
        h[34] = odd;
        h[31:0] = sid;
        return h;
    endfunction

    function automatic logic [63:0] dat(input int pid, input int b);
        return {32'hDA7A_0000 | 32'(pid), 32'(b)};
    endfunction

    function automatic logic [112:0] exp_user(input logic [31:0] sid, input logic odd, input logic has_time,
                                              input logic eob, input logic last, input logic [11:0] seq,
                                              input logic [63:0] tim);
        return {sid[0], odd, has_time, eob, last, seq, sid, tim};
    endfunction

    // Output monitor: collects transfers, counts error pulses, checks hold stability
    initial begin
        logic hold_pending;
        logic [63:0]  held_d;
        logic [112:0] held_u;
        hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || clear) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending)
                    check("hold_stable", {o_tvalid, o_tdata, o_tuser}, {1'b1, held_d, held_u});
                hold_pending = o_tvalid && !o_tready;
                held_d = o_tdata;
                held_u = o_tuser;
                if (o_tvalid && o_tready) begin
                    out_d.push_back(o_tdata);
                    out_u.push_back(o_tuser);
                end
                if (seq_err)  seq_seen++;
                if (chan_err) chan_seen++;
                if (seq_err || chan_err) check("err_exclusive", 128'(seq_err & chan_err), 128'(0));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat
    task automatic send(input logic [63:0] d, input logic last);
        int waits;
        waits = 0;
        i_tdata = d;
        i_tlast = last;
        i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready) begin
            stall_cnt++;
            waits++;
            if (waits > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: i_tready low for %0d cycles, expected acceptance", waits);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
    endtask

    task automatic run_pkt(input pkt_t p, input int pid);
        int q0, s0, c0, st0;
        q0 = out_d.size();
        s0 = seq_seen;
        c0 = chan_seen;
        st0 = stall_cnt;
        send(mk_hdr(p.drop, p.has_time, p.eob, p.seq, p.odd, p.sid), (p.nbody == 0) && !p.has_time);
        if (p.has_time) begin
            send(p.tim, p.nbody == 0);
            if (!p.drop && p.exp_chan == 0) model_time = p.tim;
        end
        for (int b = 0; b < p.nbody; b++) send(dat(pid, b), b == p.nbody - 1);
        repeat (4) @(negedge clk);
        #1;
        check($sformatf("pkt%0d_nout", pid), 128'(out_d.size() - q0), 128'(p.exp_out));
        check($sformatf("pkt%0d_seq_err", pid), 128'(seq_seen - s0), 128'(p.exp_seq * int'(SEQ_ON)));
        check($sformatf("pkt%0d_chan_err", pid), 128'(chan_seen - c0), 128'(p.exp_chan));
        check($sformatf("pkt%0d_no_stall", pid), 128'(stall_cnt - st0), 128'(0));
        for (int b = 0; b < p.exp_out && (q0 + b) < out_d.size(); b++) begin
            check($sformatf("pkt%0d_b%0d_tdata", pid, b), 128'(out_d[q0 + b]), 128'(dat(pid, b)));
            check($sformatf("pkt%0d_b%0d_tuser", pid, b), 128'(out_u[q0 + b]),
                  128'(exp_user(p.sid, p.odd, p.has_time, p.eob, b == p.nbody - 1, p.seq, model_time)));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t hp;
        int q0, s0;

        //             sid    seq       odd   tim   eob   drop  time                    nb out seq chan
        tbl[0] = '{32'd1, 12'd0,    1'b0, 1'b1, 1'b0, 1'b0, 64'h1234,               3, 3, 0, 0};
        tbl[1] = '{32'd0, 12'd0,    1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2, 2, 0, 0};
        tbl[2] = '{32'd0, 12'd1,    1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                  1, 1, 0, 0};
        tbl[3] = '{32'd0, 12'd3,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  2, 2, 1, 0};
        tbl[4] = '{32'd1, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  0, 0, 1, 0};
        tbl[5] = '{32'd1, 12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  2, 2, 0, 0};
        tbl[6] = '{32'd2, 12'd7,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  4, 0, 0, 1};
        tbl[7] = '{32'd0, 12'd4,    1'b0, 1'b0, 1'b0, 1'b1, 64'h0,                  2, 0, 0, 0};
        tbl[8] = '{32'd0, 12'd9,    1'b0, 1'b1, 1'b0, 1'b0, 64'hABCD_0000_0000_0001, 1, 1, 1, 0};
        tbl[9] = '{32'd1, 12'd1,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2, 2, 0, 0};

        reset_n = 1'b0;
        clear = 1'b0;
        i_tdata = '0;
        i_tlast = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", 128'(o_tvalid), 128'(0));
        check("rst_i_tready", 128'(i_tready), 128'(1));
        check("rst_err_pulses", 128'({seq_err, chan_err}), 128'(0));
        check("rst_err_count", 128'(err_count), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_pkt(tbl[i], i);
        check("tbl_err_count", 128'(err_count), 128'(1 + 3 * int'(SEQ_ON)));

        // Backpressure: depth-2 FIFO fills after two body beats
        o_tready = 1'b0;
        q0 = out_d.size();
        s0 = seq_seen;
        send(mk_hdr(1'b0, 1'b0, 1'b0, 12'd10, 1'b0, 32'd0), 1'b0);
        @(negedge clk);
        check("bp_pre_valid", 128'(o_tvalid), 128'(0));
        @(posedge clk);
        #1;
        send(dat(40, 0), 1'b0);
        @(negedge clk);
        check("bp_valid_latency", 128'(o_tvalid), 128'(1));
        @(posedge clk);
        #1;
        send(dat(40, 1), 1'b0);
        i_tdata = dat(40, 2);
        i_tlast = 1'b0;
        i_tvalid = 1'b1;
        @(negedge clk);
        check("bp_stall_now", 128'(i_tready), 128'(0));
        repeat (3) @(negedge clk);
        check("bp_stall_held", 128'(i_tready), 128'(0));
        check("bp_no_pop", 128'(out_d.size() - q0), 128'(0));
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        for (int b = 2; b < 10; b++) send(dat(40, b), b == 9);
        repeat (6) @(negedge clk);
        #1;
        check("bp_nout", 128'(out_d.size() - q0), 128'(10));
        check("bp_seq_err", 128'(seq_seen - s0), 128'(0));
        for (int b = 0; b < 10 && (q0 + b) < out_d.size(); b++) begin
            check($sformatf("bp_b%0d_tdata", b), 128'(out_d[q0 + b]), 128'(dat(40, b)));
            check($sformatf("bp_b%0d_tuser", b), 128'(out_u[q0 + b]),
                  128'(exp_user(32'd0, 1'b0, 1'b0, 1'b0, b == 9, 12'd10, model_time)));
        end
        @(posedge clk);
        #1;

        // Hard reset in the middle of a body
        o_tready = 1'b0;
        send(mk_hdr(1'b0, 1'b0, 1'b0, 12'd2, 1'b0, 32'd1), 1'b0);
        send(dat(41, 0), 1'b0);
        send(dat(41, 1), 1'b0);
        i_tdata = dat(41, 2);
        i_tvalid = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        i_tvalid = 1'b0;
        model_time = '0;
        @(negedge clk);
        check("mid_rst_fifo_empty", 128'(o_tvalid), 128'(0));
        check("mid_rst_err_count", 128'(err_count), 128'(0));
        check("mid_rst_i_tready", 128'(i_tready), 128'(1));
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        hp = '{32'd2, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1, 0, 0, 1};
        run_pkt(hp, 20);
        hp = '{32'd0, 12'd77, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1, 1, 0, 0};
        run_pkt(hp, 21);
        check("post_rst_err_count", 128'(err_count), 128'(1));

        // Soft clear in the middle of a body keeps err_count
        o_tready = 1'b0;
        send(mk_hdr(1'b0, 1'b0, 1'b0, 12'd78, 1'b0, 32'd0), 1'b0);
        send(dat(42, 0), 1'b0);
        send(dat(42, 1), 1'b0);
        i_tdata = dat(42, 2);
        i_tvalid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        i_tvalid = 1'b0;
        model_time = '0;
        @(negedge clk);
        check("clr_fifo_empty", 128'(o_tvalid), 128'(0));
        check("clr_err_count_held", 128'(err_count), 128'(1));
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        hp = '{32'd0, 12'd200, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1, 1, 0, 0};
        run_pkt(hp, 22);
        hp = '{32'd0, 12'd5, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1, 1, 1, 0};
        run_pkt(hp, 23);
        check("final_err_count", 128'(err_count), 128'(1 + int'(SEQ_ON)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
